// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Request/grant handshake followed by a separate read-data valid phase for loads.
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory transaction per instruction,
// aligns/extends load data, and registers the writeback value and address.
// Holds the upstream pipeline via mem_stall_o while a transaction is open.
module mem_stage #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ex_mem_reg_valid_i,
   input  logic [31:0]  ex_mem_reg_op_c_i,
   input  logic [31:0]  ex_mem_reg_sdata_i,
   input  logic [3:0]   ex_mem_reg_memctl_i,
   input  logic [4:0]   ex_mem_reg_waddr_i,
   mem_stage_if.master  dmem,
   output logic         mem_stall_o,
   output logic         mem_wb_valid_o,
   output logic [31:0]  mem_wb_data_o,
   output logic [4:0]   mem_wb_waddr_o,
   output logic         mem_misalign_o,
   output logic         mem_bus_err_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] WAIT_GNT    = 2'd1;
   localparam logic [1:0] WAIT_RVALID = 2'd2;

   localparam logic [3:0] MC_LB  = 4'd1;
   localparam logic [3:0] MC_LH  = 4'd2;
   localparam logic [3:0] MC_LW  = 4'd3;
   localparam logic [3:0] MC_LBU = 4'd4;
   localparam logic [3:0] MC_LHU = 4'd5;
   localparam logic [3:0] MC_SB  = 4'd6;
   localparam logic [3:0] MC_SH  = 4'd7;
   localparam logic [3:0] MC_SW  = 4'd8;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wb_valid_q, wb_valid_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic [4:0]       wb_waddr_q, wb_waddr_d;
   logic             misalign_q, misalign_d;
   logic             bus_err_q, bus_err_d;

   logic             is_load, is_store, is_byte, is_half, is_word, is_signed;
   logic             misaligned, mem_op;
   logic             complete, abort, timeout;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_data;

   // Decode the memory-control field into access kind, size and signedness.
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_signed = 1'b0;
      case (ex_mem_reg_memctl_i)
         MC_LB:   begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         MC_LH:   begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         MC_LW:   begin is_load  = 1'b1; end
         MC_LBU:  begin is_load  = 1'b1; is_byte = 1'b1; end
         MC_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
         MC_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
         MC_SH:   begin is_store = 1'b1; is_half = 1'b1; end
         MC_SW:   begin is_store = 1'b1; end
         default: ;
      endcase
      is_word    = (is_load | is_store) & ~is_byte & ~is_half;
      misaligned = (is_half & ex_mem_reg_op_c_i[0]) |
                   (is_word & (|ex_mem_reg_op_c_i[1:0]));
      mem_op     = (is_load | is_store) & ~misaligned;
   end

   // Bus request fields; req is gated by rst_n so it drops the moment reset asserts.
   always_comb begin
      dmem.req   = rst_n & (((state_q == IDLE) & ex_mem_reg_valid_i & mem_op) |
                            (state_q == WAIT_GNT));
      dmem.we    = is_store;
      dmem.addr  = {ex_mem_reg_op_c_i[31:2], 2'b00};
      dmem.be    = 4'hF;
      dmem.wdata = ex_mem_reg_sdata_i;
      if (is_byte) begin
         dmem.be    = 4'b0001 << ex_mem_reg_op_c_i[1:0];
         dmem.wdata = {4{ex_mem_reg_sdata_i[7:0]}};
      end else if (is_half) begin
         dmem.be    = 4'b0011 << ex_mem_reg_op_c_i[1:0];
         dmem.wdata = {2{ex_mem_reg_sdata_i[15:0]}};
      end
   end

   // Select the addressed byte/half lane of the read data and extend it.
   always_comb begin
      case (ex_mem_reg_op_c_i[1:0])
         2'd0:    ld_byte = dmem.rdata[7:0];
         2'd1:    ld_byte = dmem.rdata[15:8];
         2'd2:    ld_byte = dmem.rdata[23:16];
         default: ld_byte = dmem.rdata[31:24];
      endcase
      ld_half = ex_mem_reg_op_c_i[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
      if (is_byte) begin
         ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
      end else if (is_half) begin
         ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
      end else begin
         ld_data = dmem.rdata;
      end
   end

   // Transaction FSM with per-state wait counter; a wait that reaches the limit aborts.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      abort    = 1'b0;
      timeout  = (cnt_q == CNT_LAST);
      case (state_q)
         IDLE: begin
            if (ex_mem_reg_valid_i) begin
               if (!mem_op) begin
                  complete = 1'b1;
               end else if (dmem.gnt) begin
                  if (is_store) begin
                     complete = 1'b1;
                  end else begin
                     state_d = WAIT_RVALID;
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = WAIT_GNT;
                  cnt_d   = '0;
               end
            end
         end
         WAIT_GNT: begin
            if (dmem.gnt) begin
               cnt_d = '0;
               if (is_store) begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = WAIT_RVALID;
               end
            end else if (timeout) begin
               complete = 1'b1;
               abort    = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_RVALID: begin
            if (dmem.rvalid) begin
               complete = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
            end else if (timeout) begin
               complete = 1'b1;
               abort    = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      mem_stall_o = ex_mem_reg_valid_i & ~complete;
   end

   // Next writeback values: loaded on completion, otherwise held; pulses default low.
   always_comb begin
      wb_valid_d = complete;
      wb_data_d  = wb_data_q;
      wb_waddr_d = wb_waddr_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      if (complete) begin
         if (abort) begin
            bus_err_d  = 1'b1;
            wb_data_d  = '0;
            wb_waddr_d = '0;
         end else if (misaligned) begin
            misalign_d = 1'b1;
            wb_data_d  = '0;
            wb_waddr_d = '0;
         end else if (is_store) begin
            wb_data_d  = '0;
            wb_waddr_d = '0;
         end else if (is_load) begin
            wb_data_d  = ld_data;
            wb_waddr_d = ex_mem_reg_waddr_i;
         end else begin
            wb_data_d  = ex_mem_reg_op_c_i;
            wb_waddr_d = ex_mem_reg_waddr_i;
         end
      end
   end

   // State, counter and writeback registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_waddr_q <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_waddr_q <= wb_waddr_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign mem_wb_valid_o = wb_valid_q;
   assign mem_wb_data_o  = wb_data_q;
   assign mem_wb_waddr_o = wb_waddr_q;
   assign mem_misalign_o = misalign_q;
   assign mem_bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases followed by randomized instructions with
// randomized grant/rvalid latency, checked against a transaction-level model.
module tb_mem_stage;
   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [31:0] op_c, sdata;
   logic [3:0]  memctl;
   logic [4:0]  waddr;
   logic        stall, wbv, mis, berr;
   logic [31:0] wbd;
   logic [4:0]  wba;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [31:0] last_d;
   bit          last_d_known;
   logic [4:0]  last_a;

   always #5 clk = ~clk;

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ex_mem_reg_valid_i  (valid),
      .ex_mem_reg_op_c_i   (op_c),
      .ex_mem_reg_sdata_i  (sdata),
      .ex_mem_reg_memctl_i (memctl),
      .ex_mem_reg_waddr_i  (waddr),
      .dmem                (bus),
      .mem_stall_o         (stall),
      .mem_wb_valid_o      (wbv),
      .mem_wb_data_o       (wbd),
      .mem_wb_waddr_o      (wba),
      .mem_misalign_o      (mis),
      .mem_bus_err_o       (berr)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // 0 = no memory access, 1 = load, 2 = store
   function automatic int unsigned ref_kind(input logic [3:0] c);
      if (c >= 4'd1 && c <= 4'd5) return 1;
      if (c >= 4'd6 && c <= 4'd8) return 2;
      return 0;
   endfunction

   function automatic int unsigned ref_size(input logic [3:0] c);
      if (c == 4'd1 || c == 4'd4 || c == 4'd6) return 1;
      if (c == 4'd2 || c == 4'd5 || c == 4'd7) return 2;
      if (c == 4'd3 || c == 4'd8) return 4;
      return 0;
   endfunction

   function automatic logic ref_mis(input logic [3:0] c, input logic [31:0] a);
      int unsigned sz = ref_size(c);
      if (sz == 0) return 1'b0;
      return (a % sz) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] rd);
      int unsigned sz = ref_size(c);
      int unsigned sh;
      logic [31:0] mask, v;
      if (sz == 4) return rd;
      sh   = (a % 4) * 8;
      mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      v    = (rd >> sh) & mask;
      if ((c == 4'd1 || c == 4'd2) && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [3:0] c, input logic [31:0] a);
      int unsigned sz = ref_size(c);
      int unsigned m;
      if (sz == 4) return 4'hF;
      m = ((sz == 2) ? 3 : 1) << (a % 4);
      return 4'(m);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [3:0] c, input logic [31:0] s);
      int unsigned sz = ref_size(c);
      if (sz == 1) return (s & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (s & 32'hFFFF) * 32'h0001_0001;
      return s;
   endfunction

   // One instruction: gd = cycles from issue until gnt, rd = cycles in the
   // read-wait phase until rvalid. Irrelevant handshake lines carry noise.
   task automatic do_instr(input logic [3:0] c, input logic [31:0] a, input logic [31:0] s,
                           input logic [4:0] w, input int unsigned gd, input int unsigned rd,
                           input logic [31:0] rdat);
      int unsigned k     = ref_kind(c);
      logic        misal = ref_mis(c, a);
      logic        memop = (k != 0) && !misal;
      int unsigned phase = 0;
      int unsigned n     = 0;
      int unsigned wcnt  = 0;
      bit          done  = 0;
      @(negedge clk);
      valid  = 1'b1;
      memctl = c;
      op_c   = a;
      sdata  = s;
      waddr  = w;
      while (!done) begin
         logic g, rv, fin, err, ereq;
         if (phase == 0) begin
            g  = memop && (n == gd);
            rv = 1'($urandom % 2);
         end else begin
            rv = (wcnt == rd);
            g  = 1'($urandom % 2);
         end
         bus.gnt    = g;
         bus.rvalid = rv;
         bus.rdata  = rv ? rdat : $urandom;
         ereq = memop && (phase == 0);
         fin  = 1'b0;
         err  = 1'b0;
         if (!memop) begin
            fin = 1'b1;
         end else if (phase == 0) begin
            if (g) begin
               if (k == 2) fin = 1'b1;
            end else if (n == TO) begin
               fin = 1'b1;
               err = 1'b1;
            end
         end else begin
            if (rv) fin = 1'b1;
            else if (wcnt == TO - 1) begin
               fin = 1'b1;
               err = 1'b1;
            end
         end
         #1;
         chk1("stall", stall, !fin);
         chk1("req", bus.req, ereq);
         if (ereq) begin
            chk32("addr", bus.addr, a & ~32'h3);
            chk1("we", bus.we, k == 2);
            if (k == 2) begin
               chk32("be", {28'h0, bus.be}, {28'h0, ref_be(c, a)});
               chk32("wdata", bus.wdata, ref_wdata(c, s));
            end
         end
         @(posedge clk);
         #1;
         chk1("wb_valid", wbv, fin);
         if (fin) begin
            chk1("misalign", mis, misal);
            chk1("bus_err", berr, err);
            if (err) begin
               chk32("err_data", wbd, 32'h0);
               chk32("err_waddr", {27'h0, wba}, 32'h0);
               last_d = 32'h0; last_d_known = 1; last_a = 5'd0;
            end else if (k == 2 || misal) begin
               chk32("nowr_waddr", {27'h0, wba}, 32'h0);
               last_d_known = 0; last_a = 5'd0;
            end else if (k == 1) begin
               chk32("ld_data", wbd, ref_load(c, a, rdat));
               chk32("ld_waddr", {27'h0, wba}, {27'h0, w});
               last_d = ref_load(c, a, rdat); last_d_known = 1; last_a = w;
            end else begin
               chk32("alu_data", wbd, a);
               chk32("alu_waddr", {27'h0, wba}, {27'h0, w});
               last_d = a; last_d_known = 1; last_a = w;
            end
            done = 1;
         end else begin
            if (phase == 0 && g) begin
               phase = 1;
               wcnt  = 0;
            end else if (phase == 1) begin
               wcnt++;
            end
            n++;
            @(negedge clk);
         end
      end
   endtask

   // A bubble: no request, no retirement, writeback fields hold.
   task automatic idle_cycle();
      @(negedge clk);
      valid      = 1'b0;
      memctl     = 4'($urandom);
      op_c       = $urandom;
      bus.gnt    = 1'($urandom);
      bus.rvalid = 1'($urandom);
      #1;
      chk1("idle_req", bus.req, 1'b0);
      chk1("idle_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      chk1("idle_wb_valid", wbv, 1'b0);
      chk1("idle_misalign", mis, 1'b0);
      chk1("idle_bus_err", berr, 1'b0);
      chk32("idle_waddr_hold", {27'h0, wba}, {27'h0, last_a});
      if (last_d_known) chk32("idle_data_hold", wbd, last_d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      valid      = 1'b0;
      op_c       = '0;
      sdata      = '0;
      memctl     = '0;
      waddr      = '0;
      bus.gnt    = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata  = '0;
      last_d     = '0;
      last_a     = '0;
      last_d_known = 1;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_wb_valid", wbv, 1'b0);
      chk32("rst_data", wbd, 32'h0);
      chk32("rst_waddr", {27'h0, wba}, 32'h0);
      chk1("rst_misalign", mis, 1'b0);
      chk1("rst_bus_err", berr, 1'b0);
      chk1("rst_req", bus.req, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      do_instr(4'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
      idle_cycle();
      do_instr(4'd3, 32'h0000_0100, 32'h0, 5'd7, 2, 1, 32'hDEAD_BEEF);
      do_instr(4'd1, 32'h0000_0103, 32'h0, 5'd8, 0, 0, 32'h8011_2233);
      do_instr(4'd4, 32'h0000_0103, 32'h0, 5'd9, 1, 0, 32'h8011_2233);
      do_instr(4'd5, 32'h0000_0102, 32'h0, 5'd10, 0, 2, 32'h8011_2233);
      do_instr(4'd2, 32'h0000_0102, 32'h0, 5'd11, 0, 0, 32'h8011_2233);
      do_instr(4'd7, 32'h0000_0102, 32'hAAAA_5555, 5'd12, 0, 0, 32'h0);
      do_instr(4'd6, 32'h0000_0101, 32'h1234_56C3, 5'd13, 3, 0, 32'h0);
      do_instr(4'd3, 32'h0000_0101, 32'h0, 5'd14, 0, 0, 32'h0);
      do_instr(4'd8, 32'h0000_0200, 32'h0BAD_F00D, 5'd15, TO + 4, 0, 32'h0);
      idle_cycle();
      do_instr(4'd3, 32'h0000_0204, 32'h0, 5'd16, 1, TO + 3, 32'h1111_1111);
      do_instr(4'd12, 32'h0000_0333, 32'h0, 5'd17, 0, 0, 32'h0);
      do_instr(4'd3, 32'h0000_0300, 32'h0, 5'd18, TO, TO - 1, 32'h5A5A_A5A5);
      idle_cycle();

      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         int unsigned gd, rd;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         gd = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
         rd = ($urandom_range(0, 7) == 0) ? TO - 2 + $urandom_range(0, 3) : $urandom_range(0, 3);
         do_instr(4'($urandom_range(0, 15)), a, $urandom, 5'($urandom), gd, rd, $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      // Reset while waiting for read data: request and outputs clear, late rvalid ignored.
      @(negedge clk);
      valid      = 1'b1;
      memctl     = 4'd3;
      op_c       = 32'h0000_0400;
      waddr      = 5'd9;
      bus.gnt    = 1'b1;
      bus.rvalid = 1'b0;
      #1;
      chk1("pre_rst_req", bus.req, 1'b1);
      @(negedge clk);
      bus.gnt = 1'b0;
      #1;
      chk1("wait_rvalid_req", bus.req, 1'b0);
      chk1("wait_rvalid_stall", stall, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("midrst_req", bus.req, 1'b0);
      chk1("midrst_wb_valid", wbv, 1'b0);
      chk32("midrst_data", wbd, 32'h0);
      chk32("midrst_waddr", {27'h0, wba}, 32'h0);
      chk1("midrst_misalign", mis, 1'b0);
      chk1("midrst_bus_err", berr, 1'b0);
      valid = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      chk1("late_rvalid_wb_valid", wbv, 1'b0);
      chk32("late_rvalid_data", wbd, 32'h0);
      last_d = 32'h0; last_d_known = 1; last_a = 5'd0;
      idle_cycle();
      do_instr(4'd0, 32'h0000_00AB, 32'h0, 5'd3, 0, 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
